pe_dbuf: RTL

PE_DBUF -- requirements
Module: pe_dbuf

---
 rtl/pe_dbuf.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pe_dbuf.sv
// Weight-stationary systolic MAC cell with a double-buffered weight (shadow/active).
// Shadow weights daisy-chain through the array while the active weight keeps computing.
module pe_dbuf #(
    parameter int ACT_W    = 8,
    parameter int WT_W     = 8,
    parameter int PSUM_W   = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [ACT_W-1:0]  in_act,
    input  logic                     in_act_valid,
    input  logic signed [PSUM_W-1:0] in_psum,
    output logic signed [ACT_W-1:0]  out_act,
    output logic                     out_act_valid,
    output logic signed [PSUM_W-1:0] out_psum,
    output logic                     out_psum_valid,
    input  logic signed [WT_W-1:0]   wt_in,
    input  logic                     wt_shift_en,
    output logic signed [WT_W-1:0]   wt_out,
    input  logic                     wt_swap_in,
    output logic                     wt_swap_out,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int PROD_W = ACT_W + WT_W;

    localparam logic signed [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

    generate
        if (PSUM_W < PROD_W) begin : g_bad_psum_w
            $error("pe_dbuf: PSUM_W must be at least ACT_W+WT_W");
        end
    endgenerate

    logic signed [WT_W-1:0]   shadow_reg;
    logic signed [WT_W-1:0]   active_reg;
    logic signed [ACT_W-1:0]  act_reg;
    logic                     act_valid_reg;
    logic signed [PSUM_W-1:0] psum_reg;
    logic                     psum_valid_reg;
    logic                     swap_reg;
    logic                     ovf_reg;

    logic signed [PROD_W-1:0] product;
    logic signed [PSUM_W:0]   prod_ext;
    logic signed [PSUM_W:0]   psum_ext;
    logic signed [PSUM_W:0]   sum_wide;
    logic                     sum_ovf;
    logic signed [PSUM_W-1:0] mac_result;
    logic signed [PSUM_W-1:0] psum_next;

    // Full-precision product, then one guard bit above PSUM_W for overflow detection.
    assign product  = in_act * active_reg;
    assign prod_ext = {{(PSUM_W+1-PROD_W){product[PROD_W-1]}}, product};
    assign psum_ext = {in_psum[PSUM_W-1], in_psum};
    assign sum_wide = psum_ext + prod_ext;
    assign sum_ovf  = sum_wide[PSUM_W] ^ sum_wide[PSUM_W-1];

    generate
        if (SATURATE) begin : g_sat
            always_comb begin
                mac_result = sum_wide[PSUM_W-1:0];
                if (sum_ovf) begin
                    mac_result = sum_wide[PSUM_W] ? PSUM_MIN : PSUM_MAX;
                end
            end
        end else begin : g_wrap
            assign mac_result = sum_wide[PSUM_W-1:0];
        end
    endgenerate

    assign psum_next = in_act_valid ? mac_result : in_psum;

    // Weight double buffer: swap reads the pre-edge shadow, so shift and swap compose.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_reg <= '0;
            active_reg <= '0;
            swap_reg   <= 1'b0;
        end else begin
            if (wt_shift_en) begin
                shadow_reg <= wt_in;
            end
            if (wt_swap_in) begin
                active_reg <= shadow_reg;
            end
            swap_reg <= wt_swap_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_reg        <= '0;
            act_valid_reg  <= 1'b0;
            psum_reg       <= '0;
            psum_valid_reg <= 1'b0;
        end else begin
            act_reg        <= in_act_valid ? in_act : '0;
            act_valid_reg  <= in_act_valid;
            psum_reg       <= psum_next;
            psum_valid_reg <= in_act_valid;
        end
    end

    // Sticky overflow; a fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (in_act_valid && sum_ovf) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign out_act        = act_reg;
    assign out_act_valid  = act_valid_reg;
    assign out_psum       = psum_reg;
    assign out_psum_valid = psum_valid_reg;
    assign wt_out         = shadow_reg;
    assign wt_swap_out    = swap_reg;
    assign ovf            = ovf_reg;

endmodule
